// File: rtl/ctrl_pkg.sv
// ctrl_pkg: states, opcode fields, control encodings and default register indices
package ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  localparam logic [1:0] CLS_ALU = 2'd0, CLS_MOV = 2'd1, CLS_IMM = 2'd2, CLS_BR = 2'd3;
  localparam logic [1:0] MOV_REG = 2'd0, MOV_LOAD = 2'd1, MOV_STORE = 2'd2, MOV_FETCH = 2'd3;
  localparam logic [1:0] BR_JMP = 2'd0, BR_BR = 2'd1, BR_CALL = 2'd2, BR_HALT = 2'd3;
  localparam logic [1:0] WV_NONE = 2'd0, WV_RA = 2'd1, WV_IMM = 2'd2, WV_REG = 2'd3;
  localparam logic [1:0] FO_SEQ = 2'd0, FO_TGT = 2'd1, FO_ALT = 2'd2, FO_HALT = 2'd3;
  localparam logic [1:0] LS_NONE = 2'b00, LS_LOAD = 2'b10, LS_STORE = 2'b11;
  localparam int ACC_IDX = 4, T1_IDX = 5, RA_IDX = 6;
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] writeval_op;
    logic [1:0] fetch_op;
    logic [1:0] ldst_en;
    logic jump;
    logic we;
    logic halt;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  typedef struct packed {
    logic instr_req;
    logic [1:0] alu_op;
    logic [1:0] writeval_op;
    logic [1:0] fetch_op;
    logic [1:0] ldst_en;
    logic wr_en;
    logic jump_control;
    logic pc_en;
    logic done;
    logic busy;
  } out_t;
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational IR-to-control-field table
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 10,
  parameter int REG_AW = 3,
  parameter int ACC_REG = ACC_IDX,
  parameter int T1_REG = T1_IDX,
  parameter int RA_REG = RA_IDX
) (
  input  logic [INSTR_W-1:0] ir,
  output ctrl_t              ctrl,
  output logic [REG_AW-1:0]  wr_reg
);
  logic [1:0] cls, sub;
  logic unused_ir;
  assign cls = ir[INSTR_W-1 -: 2];
  assign sub = ir[INSTR_W-3 -: 2];
  assign unused_ir = ^ir[INSTR_W-5-REG_AW:0];
  // each class/subop sets only the fields it owns; everything else keeps the NOP default
  always_comb begin
    ctrl = CTRL_NOP;
    wr_reg = REG_AW'(ACC_REG);
    case (cls)
      CLS_ALU: begin
        ctrl.alu_op = sub;
        ctrl.we = !sub[1];
      end
      CLS_MOV: case (sub)
        MOV_REG: begin
          ctrl.we = 1'b1;
          ctrl.writeval_op = WV_REG;
          wr_reg = ir[INSTR_W-5 -: REG_AW];
        end
        MOV_LOAD: begin
          ctrl.we = 1'b1;
          ctrl.ldst_en = LS_LOAD;
          wr_reg = REG_AW'(T1_REG);
        end
        MOV_STORE: ctrl.ldst_en = LS_STORE;
        default: ctrl.fetch_op = FO_ALT;
      endcase
      CLS_IMM: begin
        ctrl.we = 1'b1;
        ctrl.writeval_op = WV_IMM;
        wr_reg = REG_AW'(T1_REG);
      end
      default: begin
        ctrl.fetch_op = sub == BR_HALT ? FO_HALT : FO_TGT;
        ctrl.jump = sub == BR_JMP || sub == BR_CALL;
        ctrl.halt = sub == BR_HALT;
        if (sub == BR_CALL) begin
          ctrl.we = 1'b1;
          ctrl.writeval_op = WV_RA;
          wr_reg = REG_AW'(RA_REG);
        end
      end
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with registered control outputs
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 10,
  parameter int REG_AW = 3,
  parameter int ACC_REG = ACC_IDX,
  parameter int T1_REG = T1_IDX,
  parameter int RA_REG = RA_IDX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_req,
  input  logic               mem_ack,
  input  logic               resume,
  output logic [1:0]         alu_op,
  output logic [1:0]         writeval_op,
  output logic [1:0]         fetch_op,
  output logic [1:0]         ldst_en,
  output logic [REG_AW-1:0]  wr_reg,
  output logic               wr_en,
  output logic               jump_control,
  output logic               pc_en,
  output logic               done,
  output logic               busy
);
  localparam logic [REG_AW-1:0] ACC = REG_AW'(ACC_REG);
  state_e state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  ctrl_t ctrl_q, ctrl_d, dec_ctrl;
  logic [REG_AW-1:0] dst_q, dst_d, dec_dst, wr_reg_q, wr_reg_d;
  out_t out_q, out_d;
  logic live;

  ctrl_decoder #(
    .INSTR_W(INSTR_W), .REG_AW(REG_AW), .ACC_REG(ACC_REG), .T1_REG(T1_REG), .RA_REG(RA_REG)
  ) u_dec (
    .ir(ir_q), .ctrl(dec_ctrl), .wr_reg(dec_dst)
  );

  // state, IR, latched control fields and output registers; reset abandons any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      ctrl_q <= CTRL_NOP;
      dst_q <= ACC;
      out_q <= '0;
      wr_reg_q <= ACC;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      ctrl_q <= ctrl_d;
      dst_q <= dst_d;
      out_q <= out_d;
      wr_reg_q <= wr_reg_d;
    end
  end

  // sequencing: capture only while requesting, latch decode, branch on op kind, wait on ack/resume
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    ctrl_d = ctrl_q;
    dst_d = dst_q;
    case (state_q)
      S_FETCH: if (out_q.instr_req && instr_valid) begin
        ir_d = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl_d = dec_ctrl;
        dst_d = dec_dst;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = ctrl_q.ldst_en != LS_NONE ? S_MEM : ctrl_q.halt ? S_HALT : S_WB;
      S_MEM: if (mem_ack) state_d = S_WB;
      S_WB: state_d = S_FETCH;
      S_HALT: if (resume) begin
        ctrl_d = CTRL_NOP;
        dst_d = ACC;
        state_d = S_WB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // outputs are computed for the state being entered so they are valid from its first cycle
  always_comb begin
    live = state_d inside {S_EXEC, S_MEM, S_WB};
    out_d = '0;
    out_d.instr_req = state_d == S_FETCH;
    out_d.busy = state_d != S_FETCH && state_d != S_HALT;
    out_d.done = state_d == S_HALT;
    out_d.alu_op = live ? ctrl_d.alu_op : 2'd0;
    out_d.writeval_op = live ? ctrl_d.writeval_op : WV_NONE;
    out_d.fetch_op = state_d == S_HALT ? FO_HALT : live ? ctrl_d.fetch_op : FO_SEQ;
    out_d.ldst_en = state_d == S_MEM ? ctrl_d.ldst_en : LS_NONE;
    out_d.jump_control = live && ctrl_d.jump;
    out_d.wr_en = state_d == S_WB && ctrl_d.we;
    out_d.pc_en = state_d == S_WB;
    wr_reg_d = live ? dst_d : ACC;
  end

  assign instr_req = out_q.instr_req;
  assign alu_op = out_q.alu_op;
  assign writeval_op = out_q.writeval_op;
  assign fetch_op = out_q.fetch_op;
  assign ldst_en = out_q.ldst_en;
  assign wr_reg = wr_reg_q;
  assign wr_en = out_q.wr_en;
  assign jump_control = out_q.jump_control;
  assign pc_en = out_q.pc_en;
  assign done = out_q.done;
  assign busy = out_q.busy;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream against a per-instruction cycle-trace model
module tb_multicycle_control_unit;
  typedef struct packed {
    logic req;
    logic [1:0] alu, wv, fo, ls;
    logic [2:0] wr;
    logic we, jmp, pc, done, busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [9:0] instr;
  logic instr_valid, mem_ack, resume, instr_req, wr_en, jump_control, pc_en, done, busy;
  logic [1:0] alu_op, writeval_op, fetch_op, ldst_en;
  logic [2:0] wr_reg;
  logic [11:0] instr2;
  logic instr_valid2, mem_ack2, resume2, instr_req2, wr_en2, jump_control2, pc_en2, done2, busy2;
  logic [1:0] alu_op2, writeval_op2, fetch_op2, ldst_en2;
  logic [3:0] wr_reg2;
  vec_t got;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .instr_req(instr_req),
    .mem_ack(mem_ack), .resume(resume), .alu_op(alu_op), .writeval_op(writeval_op),
    .fetch_op(fetch_op), .ldst_en(ldst_en), .wr_reg(wr_reg), .wr_en(wr_en),
    .jump_control(jump_control), .pc_en(pc_en), .done(done), .busy(busy)
  );

  multicycle_control_unit #(.INSTR_W(12), .REG_AW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr(instr2), .instr_valid(instr_valid2), .instr_req(instr_req2),
    .mem_ack(mem_ack2), .resume(resume2), .alu_op(alu_op2), .writeval_op(writeval_op2),
    .fetch_op(fetch_op2), .ldst_en(ldst_en2), .wr_reg(wr_reg2), .wr_en(wr_en2),
    .jump_control(jump_control2), .pc_en(pc_en2), .done(done2), .busy(busy2)
  );

  assign got = {instr_req, alu_op, writeval_op, fetch_op, ldst_en, wr_reg, wr_en, jump_control, pc_en, done, busy};

  vec_t exp_q[$];
  logic [9:0] i_instr[$];
  logic i_valid[$], i_ack[$], i_res[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  function automatic logic rb(input bit on);
    return on ? 1'($urandom_range(1)) : 1'b0;
  endfunction

  function automatic logic [9:0] rw(input bit on);
    return on ? 10'($urandom) : 10'd0;
  endfunction

  // instruction semantics: which fields an instruction sets, whether it writes, whether it halts
  function automatic void model(input logic [9:0] ins, output vec_t f, output bit wrt, output bit hlt);
    logic [1:0] c, s;
    c = ins[9:8];
    s = ins[7:6];
    f = '0;
    f.wr = 3'd4;
    wrt = 0;
    hlt = 0;
    if (c == 2'd0) begin
      f.alu = s;
      wrt = s < 2'd2;
    end else if (c == 2'd1) begin
      f.wv = s == 2'd0 ? 2'd3 : 2'd0;
      f.ls = s == 2'd1 ? 2'b10 : s == 2'd2 ? 2'b11 : 2'b00;
      f.fo = s == 2'd3 ? 2'd2 : 2'd0;
      f.wr = s == 2'd0 ? ins[5:3] : s == 2'd1 ? 3'd5 : 3'd4;
      wrt = s < 2'd2;
    end else if (c == 2'd2) begin
      f.wv = 2'd2;
      f.wr = 3'd5;
      wrt = 1;
    end else begin
      f.fo = s == 2'd3 ? 2'd3 : 2'd1;
      f.jmp = s == 2'd0 || s == 2'd2;
      hlt = s == 2'd3;
      if (s == 2'd2) begin
        f.wr = 3'd6;
        f.wv = 2'd1;
        wrt = 1;
      end
    end
  endfunction

  task automatic push(input logic v, input logic [9:0] ins, input logic a, input logic r, input vec_t e);
    i_valid.push_back(v);
    i_instr.push_back(ins);
    i_ack.push_back(a);
    i_res.push_back(r);
    exp_q.push_back(e);
  endtask

  // one instruction: k fetch stalls, m memory stalls, h halt cycles; inputs outside their phase are noise
  task automatic add_tx(input logic [9:0] ins, input int k, input int m, input int h, input bit nz);
    vec_t f, e, idle;
    bit wrt, hlt;
    idle = '0;
    idle.req = 1;
    idle.wr = 3'd4;
    for (int j = 0; j < k; j++) push(1'b0, rw(nz), rb(nz), rb(nz), idle);
    push(1'b1, ins, rb(nz), rb(nz), idle);
    model(ins, f, wrt, hlt);
    e = '0;
    e.wr = 3'd4;
    e.busy = 1;
    push(rb(nz), rw(nz), rb(nz), rb(nz), e);
    e = f;
    e.ls = 2'b00;
    e.busy = 1;
    push(rb(nz), rw(nz), rb(nz), rb(nz), e);
    if (f.ls != 2'b00) begin
      e.ls = f.ls;
      for (int j = 0; j < m; j++) push(rb(nz), rw(nz), 1'b0, rb(nz), e);
      push(rb(nz), rw(nz), 1'b1, rb(nz), e);
      e.ls = 2'b00;
    end
    if (hlt) begin
      e = '0;
      e.wr = 3'd4;
      e.done = 1;
      e.fo = 2'd3;
      for (int j = 0; j < h; j++) push(rb(nz), rw(nz), rb(nz), 1'b0, e);
      push(rb(nz), rw(nz), rb(nz), 1'b1, e);
      e = '0;
      e.wr = 3'd4;
      e.busy = 1;
      e.pc = 1;
      push(rb(nz), rw(nz), rb(nz), rb(nz), e);
    end else begin
      e.we = wrt;
      e.pc = 1;
      push(rb(nz), rw(nz), rb(nz), rb(nz), e);
    end
  endtask

  initial begin
    vec_t idle;
    rst_n = 0;
    instr = '0;
    instr_valid = 0;
    mem_ack = 0;
    resume = 0;
    instr2 = '0;
    instr_valid2 = 0;
    mem_ack2 = 0;
    resume2 = 0;
    add_tx(10'b00_01_000000, 0, 0, 0, 0);
    add_tx(10'b01_01_000000, 0, 3, 0, 0);
    add_tx(10'b11_10_000000, 0, 0, 0, 0);
    add_tx(10'b11_11_000000, 0, 0, 10, 0);
    for (int t = 0; t < 120; t++)
      add_tx(10'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4), 1);
    idle = '0;
    idle.req = 1;
    idle.wr = 3'd4;
    push(1'b0, 10'd0, 1'b0, 1'b0, idle);
    repeat (3) @(negedge clk);
    chk("reset_vec", 32'(got), 32'h80);
    chk("reset_wr_reg2", 32'(wr_reg2), 4);
    chk("reset_req2", 32'(instr_req2), 0);
    rst_n = 1;
    fork
      for (int n = 0; n < exp_q.size(); n++) begin
        @(negedge clk);
        instr = i_instr[n];
        instr_valid = i_valid[n];
        mem_ack = i_ack[n];
        resume = i_res[n];
      end
      for (int n = 0; n < exp_q.size(); n++) begin
        @(negedge clk);
        chk($sformatf("trace_cyc%0d", n), 32'(got), 32'(exp_q[n]));
        if (n == 0 || n == 4 || n == 12 || n == 31) chk($sformatf("req_at_%0d", n), 32'(instr_req), 1);
        if (n == 2) chk("alu_exec", 32'(alu_op), 1);
        if (n == 3) chk("alu_wb_wren_wrreg", 32'({wr_en, wr_reg}), 32'hc);
        if (n inside {[7:10]}) chk($sformatf("load_ldst_%0d", n), 32'(ldst_en), 2);
        if (n == 11) chk("load_wb", 32'({wr_en, wr_reg, ldst_en}), 32'h34);
        if (n == 15) chk("call_wb", 32'({wr_en, wr_reg, writeval_op, jump_control, pc_en, fetch_op}), 32'h39d);
        if (n inside {[19:29]}) chk($sformatf("halt_hold_%0d", n), 32'({done, pc_en}), 2);
        if (n == 30) chk("resume_pulse", 32'({pc_en, fetch_op, done}), 8);
      end
    join
    @(negedge clk);
    chk("w12_req", 32'(instr_req2), 1);
    instr2 = 12'b01_00_1011_0000;
    instr_valid2 = 1;
    @(negedge clk);
    instr_valid2 = 0;
    @(negedge clk);
    chk("w12_exec", 32'({wr_reg2, writeval_op2}), 32'h2f);
    @(negedge clk);
    chk("w12_wb", 32'({wr_en2, wr_reg2, writeval_op2, pc_en2}), 32'hdf);
    @(negedge clk);
    chk("store_fetch_req", 32'(instr_req), 1);
    instr = 10'b01_10_000000;
    instr_valid = 1;
    mem_ack = 0;
    resume = 0;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("store_mem_ldst", 32'(ldst_en), 3);
    @(negedge clk);
    chk("store_mem_hold", 32'(ldst_en), 3);
    #2 rst_n = 0;
    #1 chk("store_reset_vec", 32'(got), 32'h80);
    @(negedge clk);
    mem_ack = 1;
    rst_n = 1;
    @(negedge clk);
    chk("store_first_req", 32'(got), 32'h10080);
    @(negedge clk);
    chk("store_abandoned", 32'(got), 32'h10080);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
